multiple_4bit: RTL and testbench

MULTIPLE_4BIT -- requirements
Module: multiple_4bit

---
 rtl/multiple_4bit.sv | 118 +++++++++++
 tb/tb_multiple_4bit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/multiple_4bit.sv
// ---------------------------------------------------------------------------
// multiple_4bit: pipelined 4x4 unsigned shift-and-add multiplier.
//
// Ports:
//   clk      in   1  rising-edge clock
//   rst_n    in   1  asynchronous active-low reset
//   X        in   4  unsigned multiplicand, sampled every cycle
//   Y        in   4  unsigned multiplier, sampled every cycle
//   s        out  8  registered product X*Y
//   s_valid  out  1  high once s holds the product of a sampled operand pair
//
// Configuration macro: MULTIPLE_4BIT_PIPE_EN
//   undefined: X/Y register -> combinational adder chain -> s register (latency 2)
//   defined:   an extra register after the first adder (latency 3)
// ---------------------------------------------------------------------------
module multiple_4bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] X,
    input  logic [3:0] Y,
    output logic [7:0] s,
    output logic       s_valid
);

`ifdef MULTIPLE_4BIT_PIPE_EN
    localparam int unsigned Lat = 3;
`else
    localparam int unsigned Lat = 2;
`endif

    // 1-bit full adder, returns {carry_out, sum}
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
        full_add = {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
    endfunction

    // 8-bit ripple-carry adder; the final carry is dropped because the
    // partial-product sums never exceed 225.
    function automatic logic [7:0] rca8(input logic [7:0] a, input logic [7:0] b);
        logic       c;
        logic [1:0] r;
        logic [7:0] sum;
        c   = 1'b0;
        sum = 8'h00;
        for (int i = 0; i < 8; i++) begin
            r      = full_add(a[i], b[i], c);
            sum[i] = r[0];
            c      = r[1];
        end
        rca8 = sum;
    endfunction

    // Stage 1: operand registers
    logic [3:0] x_q, x_d;
    logic [3:0] y_q, y_d;

    // Stage 2: product register
    logic [7:0] s_q, s_d;

    // Valid shift register, one bit per pipeline stage
    logic [Lat-1:0] vld_q, vld_d;

    // Partial products from registered operands
    logic [7:0] pp0, pp1, pp2, pp3;

`ifdef MULTIPLE_4BIT_PIPE_EN
    logic [7:0] sum01_q, sum01_d;
    logic [7:0] pp2_q, pp2_d;
    logic [7:0] pp3_q, pp3_d;
`endif

    always_comb begin
        x_d   = X;
        y_d   = Y;
        vld_d = {vld_q[Lat-2:0], 1'b1};

        pp0 = y_q[0] ? {4'h0, x_q}         : 8'h00;
        pp1 = y_q[1] ? {3'h0, x_q, 1'b0}   : 8'h00;
        pp2 = y_q[2] ? {2'h0, x_q, 2'b00}  : 8'h00;
        pp3 = y_q[3] ? {1'b0, x_q, 3'b000} : 8'h00;

`ifdef MULTIPLE_4BIT_PIPE_EN
        sum01_d = rca8(pp0, pp1);
        pp2_d   = pp2;
        pp3_d   = pp3;
        s_d     = rca8(rca8(sum01_q, pp2_q), pp3_q);
`else
        s_d     = rca8(rca8(rca8(pp0, pp1), pp2), pp3);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= 4'h0;
            y_q     <= 4'h0;
            s_q     <= 8'h00;
            vld_q   <= '0;
`ifdef MULTIPLE_4BIT_PIPE_EN
            sum01_q <= 8'h00;
            pp2_q   <= 8'h00;
            pp3_q   <= 8'h00;
`endif
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            s_q     <= s_d;
            vld_q   <= vld_d;
`ifdef MULTIPLE_4BIT_PIPE_EN
            sum01_q <= sum01_d;
            pp2_q   <= pp2_d;
            pp3_q   <= pp3_d;
`endif
        end
    end

    assign s       = s_q;
    assign s_valid = vld_q[Lat-1];

endmodule

// File: tb/tb_multiple_4bit.sv
// ---------------------------------------------------------------------------
// tb_multiple_4bit: directed self-checking bench for multiple_4bit.
// Works for both builds; expected latency follows MULTIPLE_4BIT_PIPE_EN.
// ---------------------------------------------------------------------------
module tb_multiple_4bit;

`ifdef MULTIPLE_4BIT_PIPE_EN
    localparam int Lat = 3;
`else
    localparam int Lat = 2;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] X;
    logic [3:0] Y;
    logic [7:0] s;
    logic       s_valid;

    int vectors;
    int miscompares;
    int t;              // ticks since reset release
    logic [7:0] hist[$]; // hand/bench expected product per tick

    multiple_4bit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .X       (X),
        .Y       (Y),
        .s       (s),
        .s_valid (s_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, expv);
        end
    endtask

    // Apply one operand pair, clock it in, then check s/s_valid against the
    // product recorded Lat-1 ticks earlier (or zero while the pipe fills).
    task automatic tick(input logic [3:0] x, input logic [3:0] y, input logic [7:0] expv);
        logic [7:0] es;
        logic       ev;
        X = x;
        Y = y;
        @(posedge clk);
        #1;
        t++;
        hist.push_back(expv);
        if (t >= Lat) begin
            es = hist[t-Lat];
            ev = 1'b1;
        end else begin
            es = 8'h00;
            ev = 1'b0;
        end
        chk("s", s, es);
        chk("s_valid", {7'b0, s_valid}, {7'b0, ev});
    endtask

    // Assert reset between edges, check immediate clear, hold, release mid-cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_s_async", s, 8'h00);
        chk("rst_valid_async", {7'b0, s_valid}, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_hold", s, 8'h00);
        chk("rst_valid_hold", {7'b0, s_valid}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        hist.delete();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        t           = 0;
        X           = 4'h0;
        Y           = 4'h0;
        rst_n       = 1'b1;
        #2;
        do_reset();

        // Hold 2*2: zero until latency, then 0x04 with valid
        for (int i = 0; i < Lat + 2; i++) tick(4'd2, 4'd2, 8'h04);
        chk("hold_2x2", s, 8'h04);
        chk("hold_valid", {7'b0, s_valid}, 8'h01);

        // Back-to-back operands
        tick(4'd10, 4'd2,  8'h14);
        tick(4'd6,  4'd10, 8'h3C);
        tick(4'd11, 4'd3,  8'h21);
        tick(4'd15, 4'd3,  8'h2D);
        tick(4'd0,  4'd0,  8'h00);
        tick(4'd15, 4'd15, 8'hE1);
        tick(4'd0,  4'd9,  8'h00);
        tick(4'd7,  4'd0,  8'h00);
        for (int i = 0; i < Lat; i++) tick(4'd1, 4'd1, 8'h01);

        // Exhaustive sweep, one pair per cycle
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                tick(4'(a), 4'(b), 8'(a * b));
            end
        end
        for (int i = 0; i < Lat - 1; i++) tick(4'd0, 4'd0, 8'h00);
        chk("sweep_last_15x15", s, 8'hE1);

        // Mid-flight reset with large products in the pipe
        tick(4'd15, 4'd14, 8'hD2);
        tick(4'd13, 4'd12, 8'h9C);
        do_reset();
        // After release: no stale product, valid only after full latency
        tick(4'd3, 4'd5, 8'h0F);
        tick(4'd9, 4'd9, 8'h51);
        tick(4'd12, 4'd4, 8'h30);
        tick(4'd1, 4'd1, 8'h01);
        tick(4'd1, 4'd1, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule
